// File: rtl/reg_file_pkg.sv
// reg_file_sb shared types and default sizing.
// Imported by the register file, scoreboard and bus interface.
package reg_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_READ = 2;
    localparam int DEF_ZERO_REG = 31;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback side bundle of the register file.
// master = pipeline, slave = reg_file_sb.
interface reg_file_sb_if #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);
    logic [NUM_READ*ADDR_W-1:0] READ_REG;
    logic [NUM_READ*DATA_W-1:0] DATA_OUT;
    logic [NUM_READ-1:0]        READ_READY;
    logic [ADDR_W-1:0]          WRITE_REG;
    logic [DATA_W-1:0]          WRITE_DATA;
    logic                       REG_WRITE_ENABLE;
    logic                       ALLOC_VALID;
    logic [ADDR_W-1:0]          ALLOC_REG;
    logic                       BUSY;

    modport master (
        output READ_REG,
        output WRITE_REG,
        output WRITE_DATA,
        output REG_WRITE_ENABLE,
        output ALLOC_VALID,
        output ALLOC_REG,
        input  DATA_OUT,
        input  READ_READY,
        input  BUSY
    );

    modport slave (
        input  READ_REG,
        input  WRITE_REG,
        input  WRITE_DATA,
        input  REG_WRITE_ENABLE,
        input  ALLOC_VALID,
        input  ALLOC_REG,
        output DATA_OUT,
        output READ_READY,
        output BUSY
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for in-flight producers.
// Alloc set wins over a same-cycle writeback clear.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       set_i,
    input  logic [ADDR_W-1:0]          set_reg_i,
    input  logic                       clr_i,
    input  logic [ADDR_W-1:0]          clr_reg_i,
    input  logic [NUM_READ*ADDR_W-1:0] rd_reg_i,
    output logic [NUM_READ-1:0]        pend_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Next pending vector: clear first, then set so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d[clr_reg_i] = 1'b0;
        end
        if (set_i && (set_reg_i != ZR)) begin
            pend_d[set_reg_i] = 1'b1;
        end
    end

    // Pending register, wiped on reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Per-port pending lookup.
    always_comb begin
        pend_o = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            pend_o[p] = pend_q[rd_reg_i[p*ADDR_W +: ADDR_W]];
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with zero register, write-through bypass,
// pending scoreboard and post-reset clear sweep.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run;
    logic              wr_ok;
    logic              alloc_ok;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;
    logic [NUM_READ-1:0]        pend;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_rdy;

    assign run      = (state_q == ST_RUN);
    assign wr_ok    = run && bus.REG_WRITE_ENABLE && (bus.WRITE_REG != ZR);
    assign alloc_ok = run && bus.ALLOC_VALID && (bus.ALLOC_REG != ZR);

    // Sweep FSM state and index registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Sweep next state: walk every index once, then run.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                idx_d = idx_q;
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Array write port: sweep zeroes, otherwise writeback.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = idx_q;
        arr_data = '0;
        if (state_q == ST_CLEAR) begin
            arr_we = 1'b1;
        end else if (wr_ok) begin
            arr_we   = 1'b1;
            arr_addr = bus.WRITE_REG;
            arr_data = bus.WRITE_DATA;
        end
    end

    // Register array, no reset; the sweep defines its contents.
    always_ff @(posedge CLK) begin
        if (RESET_N && arr_we) begin
            mem_q[arr_addr] <= arr_data;
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .set_i     (alloc_ok),
        .set_reg_i (bus.ALLOC_REG),
        .clr_i     (wr_ok),
        .clr_reg_i (bus.WRITE_REG),
        .rd_reg_i  (bus.READ_REG),
        .pend_o    (pend)
    );

    // Read muxes: zero reg, then bypass, then array with pending.
    always_comb begin
        rd_data = '0;
        rd_rdy  = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (run) begin
                if (bus.READ_REG[p*ADDR_W +: ADDR_W] == ZR) begin
                    rd_rdy[p] = 1'b1;
                end else if ((BYPASS != 0) && bus.REG_WRITE_ENABLE &&
                             (bus.WRITE_REG ==
                              bus.READ_REG[p*ADDR_W +: ADDR_W])) begin
                    rd_data[p*DATA_W +: DATA_W] = bus.WRITE_DATA;
                    rd_rdy[p] = 1'b1;
                end else begin
                    rd_data[p*DATA_W +: DATA_W] =
                        mem_q[bus.READ_REG[p*ADDR_W +: ADDR_W]];
                    rd_rdy[p] = !pend[p];
                end
            end
        end
    end

    assign bus.DATA_OUT   = rd_data;
    assign bus.READ_READY = rd_rdy;
    assign bus.BUSY       = !run;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb with three read ports and bypass,
// checked against an array/flag model of the register rules.
module tb_reg_file_sb;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n;

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus ();

    reg_file_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_READ (NR),
        .ZERO_REG (31),
        .BYPASS   (1)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_mem [32];
    bit            m_pend [32];
    bit            m_clear = 1'b1;
    int            m_cnt = 0;
    bit            m_known = 1'b0;

    logic [4:0]    rr [NR];

    task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic we,
                         input logic [4:0] wr, input logic [DW-1:0] wd,
                         input logic al, input logic [4:0] ar);
        rr[0] = r0;
        rr[1] = r1;
        rr[2] = r2;
        bus.READ_REG = {r2, r1, r0};
        bus.REG_WRITE_ENABLE = we;
        bus.WRITE_REG = wr;
        bus.WRITE_DATA = wd;
        bus.ALLOC_VALID = al;
        bus.ALLOC_REG = ar;
    endtask

    task automatic check_outputs();
        logic [DW-1:0] ed;
        logic          er;
        logic [DW-1:0] gd;
        logic          gr;
        if (!m_known) return;
        tests++;
        assert (bus.BUSY === m_clear)
        else begin
            fails++;
            $error("FAIL busy got %b exp %b", bus.BUSY, m_clear);
        end
        for (int p = 0; p < NR; p++) begin
            if (m_clear) begin
                ed = '0;
                er = 1'b0;
            end else if (rr[p] == 5'd31) begin
                ed = '0;
                er = 1'b1;
            end else if (bus.REG_WRITE_ENABLE && bus.WRITE_REG == rr[p]) begin
                ed = bus.WRITE_DATA;
                er = 1'b1;
            end else begin
                ed = m_mem[rr[p]];
                er = !m_pend[rr[p]];
            end
            gd = bus.DATA_OUT[p*DW +: DW];
            gr = bus.READ_READY[p];
            tests++;
            assert (gd === ed)
            else begin
                fails++;
                $error("FAIL data p%0d r%0d got %h exp %h", p, rr[p], gd, ed);
            end
            tests++;
            assert (gr === er)
            else begin
                fails++;
                $error("FAIL ready p%0d r%0d got %b exp %b", p, rr[p], gr, er);
            end
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_known = 1'b1;
            m_clear = 1'b1;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (m_clear) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_clear = 1'b0;
        end else begin
            if (bus.REG_WRITE_ENABLE && bus.WRITE_REG != 5'd31) begin
                m_mem[bus.WRITE_REG] = bus.WRITE_DATA;
                m_pend[bus.WRITE_REG] = 1'b0;
            end
            if (bus.ALLOC_VALID && bus.ALLOC_REG != 5'd31) begin
                m_pend[bus.ALLOC_REG] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        #4;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [4:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        rst_n = 1'b0;
        drive(0, 1, 2, 0, 0, '0, 0, 0);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(33);
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 5'(i), 0, 0, '0, 0, 0);
            cycle();
        end

        drive(1, 1, 2, 1, 1, 64'h5, 0, 0);
        cycle();
        drive(1, 2, 1, 0, 0, '0, 0, 0);
        cycle();

        drive(31, 31, 1, 1, 31, 64'hFFFF, 0, 0);
        cycle();
        drive(31, 31, 31, 0, 0, '0, 1, 31);
        cycle();
        drive(31, 1, 31, 0, 0, '0, 0, 0);
        cycle();

        drive(3, 3, 1, 0, 0, '0, 1, 3);
        cycle();
        drive(3, 3, 3, 0, 0, '0, 0, 0);
        cycle();
        drive(3, 4, 3, 1, 3, 64'hFFFF, 0, 0);
        cycle();
        drive(3, 3, 3, 0, 0, '0, 0, 0);
        cycle();
        drive(3, 3, 3, 1, 3, 64'h1234, 1, 3);
        cycle();
        drive(3, 3, 3, 0, 0, '0, 0, 0);
        cycle();

        drive(2, 2, 2, 1, 2, 64'h5, 0, 0);
        cycle();
        drive(2, 2, 2, 0, 0, '0, 0, 0);
        cycle();

        drive(5, 6, 7, 0, 0, '0, 1, 5);
        cycle();
        drive(5, 6, 7, 0, 0, '0, 1, 6);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(10);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(33);
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(i), 5'(i), 0, 0, '0, 0, 0);
            cycle();
        end

        for (int i = 0; i < 600; i++) begin
            drive(pick(), pick(), pick(), 1'($urandom_range(0, 1)), pick(),
                  {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
                  pick());
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
            if (!rst_n) begin
                rst_n = 1'b1;
                drive(0, 1, 2, 0, 0, '0, 0, 0);
                idle(33);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the LEGv8 datapath register file. It provides a configurable number of asynchronous read ports, one synchronous write port with write-through bypass, and a hardwired zero register. It also has a per-register pending scoreboard for the pipelined core, and a post-reset clear sweep that leaves every register at a defined zero value. It sits between decode (read/allocate) and writeback (write) in the pipeline.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 31, index hardwired to zero (XZR)
- BYPASS, 1, 1 = same-cycle write-through to read ports; 0 = none

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  synchronous, active-low reset
- READ_REG  in  NUM_READ*ADDR_W  read indices, port p at [p*ADDR_W +: ADDR_W]
- DATA_OUT  out  NUM_READ*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- READ_READY  out  NUM_READ  port p operand valid (not pending, or bypassed)
- WRITE_REG  in  ADDR_W  writeback index
- WRITE_DATA  in  DATA_W  writeback data
- REG_WRITE_ENABLE  in  1  writeback strobe
- ALLOC_VALID  in  1  decode marks ALLOC_REG as having an in-flight producer
- ALLOC_REG  in  ADDR_W  destination being allocated
- BUSY  out  1  clear sweep in progress; writes and allocs ignored

## Operation
- States: CLEAR, RUN. RESET_N low at an edge: state=CLEAR, sweep index=0, all pending bits=0.
- CLEAR: each cycle writes 0 to REGISTER[index], index+1; after writing index DEPTH-1, goes to RUN. BUSY=1 throughout CLEAR. REG_WRITE_ENABLE/ALLOC_VALID ignored. DATA_OUT forced to 0; READ_READY forced to 0.
- RUN: REG_WRITE_ENABLE=1 and WRITE_REG!=ZERO_REG writes REGISTER[WRITE_REG] at the edge and clears pending[WRITE_REG].
- ALLOC_VALID=1 and ALLOC_REG!=ZERO_REG sets pending[ALLOC_REG] at the edge.
- Alloc and write to the same register in the same cycle: the set wins (pending stays 1; the new producer supersedes).
- Read port p, combinational, RUN only:
  - READ_REG_p==ZERO_REG: DATA_OUT_p=0, READY_p=1.
  - Otherwise, if BYPASS=1, REG_WRITE_ENABLE=1 and WRITE_REG==READ_REG_p: DATA_OUT_p=WRITE_DATA, READY_p=1.
  - Otherwise: DATA_OUT_p=REGISTER[READ_REG_p], READY_p=!pending[READ_REG_p].
- Writes to ZERO_REG are dropped; pending[ZERO_REG] is never set.
- Multiple ports reading the same index return identical data.

## Timing
- Reset values: BUSY=1, DATA_OUT=0, READ_READY=0, from the first edge sampled with RESET_N low.
- Clear sweep takes exactly DEPTH cycles after the first edge with RESET_N high. BUSY falls after edge DEPTH (32 cycles by default).
- Reset asserted mid-sweep or in RUN restarts the sweep from index 0 and clears all pending bits. Register contents are zero only after a completed sweep.
- Write latency: visible on the array read path the cycle after the edge. With BYPASS=1 it is also visible in the same cycle.
- Pending set/clear is effective the cycle after the edge. READY_p is combinational on READ_REG_p.

## Structure
- Package reg_file_pkg: state enum (CLEAR, RUN), default parameter constants (DATA_W, ADDR_W, ZERO_REG = 31).
- Sub-module reg_scoreboard: DEPTH pending bits, set/clear/priority logic, NUM_READ lookup outputs. The top level holds the array, the sweep FSM and the read muxes.

## Test plan
- Reset, then release: BUSY=1 for 32 cycles then 0. Reading indices 0..30 returns 0 with READY=1.
- Write 0x0005 to X1; the next cycle, port0 reads X1 = 0x0005. With BYPASS=1, the same-cycle read of X1 returns 0x0005.
- Write 0xFFFF to X31, then read X31: 0, READY=1. ALLOC X31: READY stays 1.
- ALLOC X3: the next cycle, READY for X3 is 0. A write to X3 with 0xFFFF gives READY=1 in the same cycle (bypass) and stays 1 after. ALLOC+write to X3 in the same cycle leaves READY=0.
- Reset asserted at sweep index 10: the sweep restarts at 0, BUSY stays high for a further 32 cycles, and pending bits are all 0.
- NUM_READ=3, all ports read X2 while X2 is written 0x0005: all three outputs equal 0x0005.
